sha1_padder: RTL

SHA1_PADDER -- requirements
Module: sha1_padder

---
 rtl/sha1_padder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sha1_padder.sv
// SHA-1 message padder: collects 32-bit big-endian message beats into a
// 16-word block, appends the 0x80 marker, zero fill and 64-bit bit length,
// and streams each block into the compression core (load x16, then start).
// Optional status output blk_count is enabled by defining SHA1_PADDER_STATUS_EN.
module sha1_padder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    input  logic        core_busy,
    output logic [31:0] din,
    output logic        load,
    output logic        start,
    output logic        use_prev_cv,
    output logic        msg_done
`ifdef SHA1_PADDER_STATUS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [2:0] {StFill, StPad, StSend, StStart, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [60:0] cnt_q, cnt_d;
    logic        marker_pend_q, marker_pend_d;  // 0x80000000 still to be written at idx
    logic        zero_only_q, zero_only_d;      // current block cannot hold the length
    logic        pad_pend_q, pad_pend_d;        // a further pad-only block must follow
    logic        final_q, final_d;              // block in flight carries the length
    logic        prev_q, prev_d;                // a block of this message was already started
    logic        wait_first_q, wait_first_d;
    logic [31:0] blk_buf_q [16];

    logic        buf_we;
    logic [31:0] buf_wdata;
    logic [2:0]  n_eff;
    logic [31:0] keep_mask;
    logic [31:0] marker_word;
    logic        pad_zo;

`ifdef SHA1_PADDER_STATUS_EN
    logic [15:0] blk_count_q, blk_count_d;
    assign blk_count = blk_count_q;
`endif

    // Byte count of the beat and the mask/marker used for a partial last beat.
    always_comb begin
        n_eff = 3'd4;
        if (in_last) begin
            n_eff = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        end
        keep_mask   = 32'h0000_0000;
        marker_word = 32'h8000_0000;
        unique case (n_eff)
            3'd1: begin keep_mask = 32'hFF00_0000; marker_word = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hFFFF_0000; marker_word = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hFFFF_FF00; marker_word = 32'h0000_0080; end
            default: begin keep_mask = 32'h0000_0000; marker_word = 32'h8000_0000; end
        endcase
    end

    // Next-state and output decode for the fill/pad/send/start/wait sequence.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        marker_pend_d = marker_pend_q;
        zero_only_d   = zero_only_q;
        pad_pend_d    = pad_pend_q;
        final_d       = final_q;
        prev_d        = prev_q;
        wait_first_d  = wait_first_q;
        buf_we        = 1'b0;
        buf_wdata     = 32'h0;
        pad_zo        = 1'b0;
        in_ready      = 1'b0;
        load          = 1'b0;
        start         = 1'b0;
        use_prev_cv   = 1'b0;
        msg_done      = 1'b0;
        din           = 32'h0;
`ifdef SHA1_PADDER_STATUS_EN
        blk_count_d   = blk_count_q;
`endif
        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d  = cnt_q + 61'(n_eff);
                    buf_we = 1'b1;
                    idx_d  = idx_q + 4'd1;
                    if (!in_last) begin
                        buf_wdata = in_data;
                        if (idx_q == 4'd15) state_d = StSend;
                    end else if (n_eff == 3'd4) begin
                        // Full last word: marker goes into the following slot.
                        buf_wdata     = in_data;
                        marker_pend_d = 1'b1;
                        if (idx_q == 4'd15) begin
                            state_d    = StSend;
                            pad_pend_d = 1'b1;
                        end else begin
                            state_d = StPad;
                        end
                    end else begin
                        buf_wdata = (in_data & keep_mask) | marker_word;
                        if (idx_q == 4'd15) begin
                            state_d    = StSend;
                            pad_pend_d = 1'b1;
                        end else begin
                            state_d     = StPad;
                            zero_only_d = (idx_q == 4'd14);
                        end
                    end
                end
            end
            StPad: begin
                buf_we = 1'b1;
                idx_d  = idx_q + 4'd1;
                // Marker in slot 14/15 leaves no room for the length.
                pad_zo = zero_only_q | (marker_pend_q & (idx_q >= 4'd14));
                if (marker_pend_q) begin
                    buf_wdata     = 32'h8000_0000;
                    marker_pend_d = 1'b0;
                    zero_only_d   = pad_zo;
                end else if (!zero_only_q && idx_q == 4'd14) begin
                    buf_wdata = cnt_q[60:29];
                end else if (!zero_only_q && idx_q == 4'd15) begin
                    buf_wdata = {cnt_q[28:0], 3'b000};
                end
                if (idx_q == 4'd15) begin
                    state_d     = StSend;
                    zero_only_d = 1'b0;
                    pad_pend_d  = pad_zo;
                    final_d     = !pad_zo;
                end
            end
            StSend: begin
                load  = 1'b1;
                din   = blk_buf_q[idx_q];
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = StStart;
            end
            StStart: begin
                start        = 1'b1;
                use_prev_cv  = prev_q;
                prev_d       = 1'b1;
                wait_first_d = 1'b1;
                state_d      = StWait;
`ifdef SHA1_PADDER_STATUS_EN
                blk_count_d  = blk_count_q + 16'd1;
`endif
            end
            StWait: begin
                // The core may not have raised busy yet on the first cycle.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!core_busy) begin
                    idx_d = 4'd0;
                    if (final_q) begin
                        msg_done = 1'b1;
                        state_d  = StFill;
                        cnt_d    = 61'd0;
                        prev_d   = 1'b0;
                        final_d  = 1'b0;
`ifdef SHA1_PADDER_STATUS_EN
                        blk_count_d = 16'd0;
`endif
                    end else if (pad_pend_q) begin
                        state_d    = StPad;
                        pad_pend_d = 1'b0;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFill;
            idx_q         <= 4'd0;
            cnt_q         <= 61'd0;
            marker_pend_q <= 1'b0;
            zero_only_q   <= 1'b0;
            pad_pend_q    <= 1'b0;
            final_q       <= 1'b0;
            prev_q        <= 1'b0;
            wait_first_q  <= 1'b0;
`ifdef SHA1_PADDER_STATUS_EN
            blk_count_q   <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            marker_pend_q <= marker_pend_d;
            zero_only_q   <= zero_only_d;
            pad_pend_q    <= pad_pend_d;
            final_q       <= final_d;
            prev_q        <= prev_d;
            wait_first_q  <= wait_first_d;
`ifdef SHA1_PADDER_STATUS_EN
            blk_count_q   <= blk_count_d;
`endif
        end
    end

    // Block buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we) blk_buf_q[idx_q] <= buf_wdata;
    end

endmodule
